// File: rtl/random_range_generator.sv
// random_range_generator: draws uniformly distributed values in [MIN, MAX]
// from a free-running Galois LFSR, with player "fly" presses mixing in a
// timing-dependent counter. Values are produced on a req/valid handshake
// using bounded rejection sampling with a single folded fallback draw.
module random_range_generator #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] POLY      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter int               OUT_W     = 10,
  parameter int               MIN       = 40,
  parameter int               MAX       = 360,
  parameter int               MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fly,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] num
);

  // Number of values in the output range and the candidate width that covers it.
  localparam int SPAN   = MAX - MIN + 1;
  localparam int MASK_W = (SPAN <= 1) ? 1 : $clog2(SPAN);
  localparam int TRY_W  = (MAX_TRIES <= 1) ? 1 : $clog2(MAX_TRIES);

  localparam logic [MASK_W:0]  SPAN_C   = SPAN[MASK_W:0];
  localparam logic [OUT_W-1:0] MIN_O    = OUT_W'(MIN);
  localparam logic [OUT_W-1:0] SPAN_O   = OUT_W'(SPAN);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic {
    IDLE,
    DRAW
  } state_t;

  state_t             state, state_next;
  logic [TRY_W-1:0]   tries, tries_next;
  logic [WIDTH-1:0]   lfsr, lfsr_step, lfsr_pick, lfsr_next;
  logic [WIDTH-1:0]   ent_cnt;
  logic               fly_d;
  logic               fly_rise;
  logic [MASK_W-1:0]  cand;
  logic [OUT_W-1:0]   num_next;
  logic               valid_next;
  logic               busy_next;

  assign fly_rise = fly & ~fly_d;
  assign cand     = lfsr[MASK_W-1:0];

  // LFSR next value: seed load beats entropy mixing beats a plain step;
  // an all-zero result would lock the LFSR, so it is replaced by SEED.
  always_comb begin
    lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);
    if (seed_load) begin
      lfsr_pick = seed;
    end else if (fly_rise) begin
      lfsr_pick = lfsr_step ^ ent_cnt;
    end else begin
      lfsr_pick = lfsr_step;
    end
    lfsr_next = (lfsr_pick == '0) ? SEED : lfsr_pick;
  end

  // Draw FSM: accept an in-range candidate, retry on rejection, and fold
  // the candidate back into range on the last permitted try.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a value unassigned and infer a latch.
    state_next = state;
    tries_next = tries;
    num_next   = num;
    valid_next = 1'b0;
    busy_next  = busy;
    unique case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (req) begin
          state_next = DRAW;
          tries_next = '0;
          busy_next  = 1'b1;
        end
      end
      DRAW: begin
        if ({1'b0, cand} < SPAN_C) begin
          num_next   = MIN_O + OUT_W'(cand);
          valid_next = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (tries == LAST_TRY) begin
          // cand < 2*SPAN, so subtracting SPAN lands inside the range.
          num_next   = MIN_O + (OUT_W'(cand) - SPAN_O);
          valid_next = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          tries_next = tries + TRY_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, matching hardware.
    if (!rst_n) begin
      lfsr    <= SEED;
      ent_cnt <= '0;
      fly_d   <= 1'b0;
      state   <= IDLE;
      tries   <= '0;
      num     <= MIN_O;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      lfsr    <= lfsr_next;
      ent_cnt <= ent_cnt + WIDTH'(1);
      fly_d   <= fly;
      state   <= state_next;
      tries   <= tries_next;
      num     <= num_next;
      valid   <= valid_next;
      busy    <= busy_next;
    end
  end

endmodule

// File: tb/tb_random_range_generator.sv
// Self-checking bench for random_range_generator (default parameters):
// directed vector tables, hand-written multi-cycle sequences and a
// cycle-by-cycle reference model under random stimulus.
module tb_random_range_generator;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        fly       = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed      = 16'h0000;
  logic        req       = 1'b0;
  logic        busy;
  logic        valid;
  logic [9:0]  num;

  int checks = 0;
  int errors = 0;

  // Reference copy of the entropy counter: cleared by reset, +1 otherwise.
  logic [15:0] ent_ref = 16'h0000;

  random_range_generator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fly       (fly),
    .seed_load (seed_load),
    .seed      (seed),
    .req       (req),
    .busy      (busy),
    .valid     (valid),
    .num       (num)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) ent_ref <= 16'h0000;
    else        ent_ref <= ent_ref + 16'h0001;
  end

  typedef struct {
    logic [15:0] seed;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] e2;
  } step_vec_t;

  typedef struct {
    logic [15:0] seed;
    logic [9:0]  exp_num;
    int          exp_draws;
  } draw_vec_t;

  step_vec_t step_tab[4];
  draw_vec_t draw_tab[6];

  // Reference model state.
  logic [15:0] m_lfsr;
  logic [15:0] m_ent;
  logic        m_fly_d;
  logic        m_draw;
  int          m_tries;
  logic [9:0]  m_num;
  logic        m_valid;
  logic        m_busy;

  function automatic logic [15:0] step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the reference model by one edge using the inputs now applied.
  task automatic model_step();
    logic [15:0] pick;
    logic [8:0]  cand;
    if (!rst_n) begin
      m_lfsr = 16'hACE1; m_ent = '0; m_fly_d = 1'b0; m_draw = 1'b0;
      m_tries = 0; m_num = 10'd40; m_valid = 1'b0; m_busy = 1'b0;
    end else begin
      cand = m_lfsr[8:0];
      if (seed_load)           pick = seed;
      else if (fly && !m_fly_d) pick = step(m_lfsr) ^ m_ent;
      else                     pick = step(m_lfsr);
      m_valid = 1'b0;
      if (!m_draw) begin
        m_busy = 1'b0;
        if (req) begin m_draw = 1'b1; m_tries = 0; m_busy = 1'b1; end
      end else if (cand < 9'd321) begin
        m_num = 10'd40 + 10'(cand); m_valid = 1'b1; m_busy = 1'b0; m_draw = 1'b0;
      end else if (m_tries == 3) begin
        m_num = 10'd40 + 10'(cand) - 10'd321; m_valid = 1'b1; m_busy = 1'b0; m_draw = 1'b0;
      end else begin
        m_tries++;
      end
      m_lfsr  = (pick == 16'h0000) ? 16'hACE1 : pick;
      m_fly_d = fly;
      m_ent   = m_ent + 16'h0001;
    end
  endtask

  logic [15:0] run_a[150];
  logic [15:0] run_b[150];

  initial begin
    int n;
    int cnt;
    logic [15:0] e_mix;

    step_tab[0] = '{16'h0001, 16'h0001, 16'hB400, 16'h5A00};
    step_tab[1] = '{16'h0000, 16'hACE1, 16'hE270, 16'h7138};
    step_tab[2] = '{16'h0002, 16'h0002, 16'h0001, 16'hB400};
    step_tab[3] = '{16'h8000, 16'h8000, 16'h4000, 16'h2000};

    draw_tab[0] = '{16'h0000, 10'd265, 1};
    draw_tab[1] = '{16'h1140, 10'd360, 1};
    draw_tab[2] = '{16'h0001, 10'd41,  1};
    draw_tab[3] = '{16'hFE00, 10'd40,  1};
    draw_tab[4] = '{16'h0141, 10'd200, 2};
    draw_tab[5] = '{16'h01FF, 10'd295, 2};

    // Reset held with req and fly high.
    rst_n = 1'b0; req = 1'b1; fly = 1'b1;
    repeat (3) tick();
    check("rst_lfsr", dut.lfsr, 16'hACE1);
    check("rst_num", num, 10'd40);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rel_busy", busy, 1'b1);
    check("rel_lfsr", dut.lfsr, 16'hE270);
    req = 1'b0; fly = 1'b0;
    tick();
    check("rel_valid", valid, 1'b1);
    check("rel_num", num, 10'd152);
    tick();
    check("rel_valid_pulse", valid, 1'b0);
    check("rel_num_hold", num, 10'd152);

    // Seed load and step sequences.
    foreach (step_tab[i]) begin
      seed_load = 1'b1; seed = step_tab[i].seed;
      tick();
      seed_load = 1'b0;
      check($sformatf("step%0d_e0", i), dut.lfsr, step_tab[i].e0);
      tick();
      check($sformatf("step%0d_e1", i), dut.lfsr, step_tab[i].e1);
      tick();
      check($sformatf("step%0d_e2", i), dut.lfsr, step_tab[i].e2);
    end

    // From lfsr=B400 the candidate is 0 and is accepted.
    seed_load = 1'b1; seed = 16'h0001;
    tick();
    seed_load = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    check("b400_lfsr", dut.lfsr, 16'hB400);
    check("b400_busy", busy, 1'b1);
    check("b400_nopulse", valid, 1'b0);
    tick();
    check("b400_valid", valid, 1'b1);
    check("b400_num", num, 10'd40);

    // Draw table: load seed and request on the same edge.
    foreach (draw_tab[i]) begin
      seed_load = 1'b1; seed = draw_tab[i].seed; req = 1'b1;
      tick();
      seed_load = 1'b0; req = 1'b0;
      check($sformatf("draw%0d_busy", i), busy, 1'b1);
      n = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        n++;
        if (valid) break;
      end
      check($sformatf("draw%0d_draws", i), n, draw_tab[i].exp_draws);
      check($sformatf("draw%0d_num", i), num, draw_tab[i].exp_num);
    end

    // Fallback: four rejected candidates of 9'h1FF fold to 40+190.
    seed_load = 1'b1; seed = 16'h01FF; req = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("fb_wait%0d", k), {busy, valid}, 2'b10);
    end
    seed_load = 1'b0;
    tick();
    check("fb_valid", valid, 1'b1);
    check("fb_num", num, 10'd230);

    // req while busy is ignored: exactly one valid.
    seed_load = 1'b1; seed = 16'h0141; req = 1'b1;
    tick();
    seed_load = 1'b0;
    tick();
    req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (valid) cnt++;
    end
    check("busy_req_ignored", cnt, 1);

    // Simultaneous seed_load and fly rise: seed wins.
    fly = 1'b1; seed_load = 1'b1; seed = 16'h1234;
    tick();
    fly = 1'b0; seed_load = 1'b0;
    check("seed_beats_fly", dut.lfsr, 16'h1234);

    // Entropy: run A without fly, run B with fly rising before edge 50 and held.
    seed_load = 1'b1; seed = 16'h5EED;
    tick();
    seed_load = 1'b0;
    for (int i = 0; i < 150; i++) begin
      run_a[i] = dut.lfsr;
      tick();
    end
    seed_load = 1'b1; seed = 16'h5EED;
    tick();
    seed_load = 1'b0;
    e_mix = 16'h0000;
    for (int i = 0; i < 150; i++) begin
      run_b[i] = dut.lfsr;
      if (i == 49) begin
        fly = 1'b1;
        e_mix = ent_ref;
      end
      tick();
    end
    fly = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) if (run_a[i] !== run_b[i]) cnt++;
    check("ent_prefix_equal", cnt, 0);
    check("ent_mix_value", run_b[50], run_a[50] ^ e_mix);
    check("ent_diverged", run_b[60] == run_a[60], 1'b0);
    cnt = 0;
    for (int i = 51; i < 150; i++) if (run_b[i] !== step(run_b[i-1])) cnt++;
    check("ent_held_single_mix", cnt, 0);

    // Reset in the middle of a draw.
    seed_load = 1'b1; seed = 16'h01FF; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    check("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0; seed_load = 1'b0;
    tick();
    check("mid_rst", {busy, valid, num}, {1'b0, 1'b0, 10'd40});
    check("mid_rst_lfsr", dut.lfsr, 16'hACE1);
    rst_n = 1'b1;
    tick();
    check("mid_rst_idle", busy, 1'b0);

    // Random stimulus against the reference model.
    rst_n = 1'b0;
    model_step();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) fly = ~fly;
      seed_load = ($urandom_range(0, 31) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      model_step();
      tick();
      check("model_cycle", {dut.lfsr, valid, busy, num}, {m_lfsr, m_valid, m_busy, m_num});
      if (valid) check("range", (num >= 10'd40) && (num <= 10'd360), 1'b1);
      if (dut.lfsr == 16'h0000) cnt++;
    end
    check("lfsr_nonzero", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
